// File: rtl/cmp_chk_pkg.sv
// Shared types, defaults and the reference equality function for the
// 2-bit comparator response checker and its bench.
package cmp_chk_pkg;

  localparam int unsigned WIDTH_DEF = 2;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Operands are zero-extended by the caller so any WIDTH up to 32 fits.
  function automatic logic exp_eq(input logic [31:0] a, input logic [31:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/cmp_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the clear
// cycle counts as the first event of the new run.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = inc ? W'(1) : '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cmp_resp_checker.sv
// Response checker for the equality comparator: counts vectors and mismatches,
// captures the first failing vector and issues a pass/fail verdict per session.
module cmp_resp_checker
  import cmp_chk_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             z,
  input  logic             done,
  output logic             busy,
  output logic             result_valid,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_x,
  output logic [WIDTH-1:0] first_err_y,
  output logic [CNT_W-1:0] first_err_idx
);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] fx_q, fx_d;
  logic [WIDTH-1:0] fy_q, fy_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;

  logic             clr;
  logic             count_en;
  logic             mismatch;
  logic             err_zero_eff;
  logic [CNT_W-1:0] vec_eff;

  always_comb begin
    state_d      = state_q;
    clr          = 1'b0;
    pass_d       = pass_q;
    fail_d       = fail_q;
    fx_d         = fx_q;
    fy_d         = fy_q;
    fidx_d       = fidx_q;
    mismatch     = (z != exp_eq(32'(x), 32'(y)));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          clr = 1'b1;
        end else if (done) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        clr     = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_en     = sample_valid && (clr || (state_q == RUN));
    err_zero_eff = clr || (err_count == '0);
    vec_eff      = clr ? '0 : vec_count;

    if (clr) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
      fx_d   = '0;
      fy_d   = '0;
      fidx_d = '0;
    end

    if (count_en && mismatch && err_zero_eff) begin
      fx_d   = x;
      fy_d   = y;
      fidx_d = vec_eff;
    end

    // Verdict is built from the post-edge counts so a sample coincident
    // with done is included and the verdict lines up with result_valid.
    if ((state_q == RUN) && !start && done) begin
      pass_d = (err_count == '0) && !(count_en && mismatch)
               && ((vec_count != '0) || count_en);
      fail_d = !pass_d;
    end

    busy_d = (state_d == RUN);
    rv_d   = (state_d == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fidx_q  <= fidx_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (count_en),
    .q   (vec_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (count_en && mismatch),
    .q   (err_count)
  );

  assign busy          = busy_q;
  assign result_valid  = rv_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign first_err_x   = fx_q;
  assign first_err_y   = fy_q;
  assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_cmp_resp_checker.sv
// Directed bench for cmp_resp_checker: table-driven sessions plus hand-written
// corner sequences (coincident done, saturation, async reset, restart).
module tb_cmp_resp_checker;
  import cmp_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic       done = 1'b0;
  logic       z = 1'b0;
  logic [1:0] x = '0;
  logic [1:0] y = '0;

  logic       busy, result_valid, pass, fail;
  logic [7:0] vec_count, err_count, first_err_idx;
  logic [1:0] first_err_x, first_err_y;

  logic       busy3, result_valid3, pass3, fail3;
  logic [2:0] vec_count3, err_count3, first_err_idx3;
  logic [1:0] first_err_x3, first_err_y3;

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [1:0] x;
    logic [1:0] y;
    logic       z;
    logic [7:0] exp_vec;
  } vec_t;

  vec_t tbl [9];

  cmp_resp_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .x(x), .y(y), .z(z), .done(done), .busy(busy), .result_valid(result_valid),
    .pass(pass), .fail(fail), .vec_count(vec_count), .err_count(err_count),
    .first_err_x(first_err_x), .first_err_y(first_err_y),
    .first_err_idx(first_err_idx)
  );

  cmp_resp_checker #(.WIDTH(2), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .x(x), .y(y), .z(z), .done(done), .busy(busy3), .result_valid(result_valid3),
    .pass(pass3), .fail(fail3), .vec_count(vec_count3), .err_count(err_count3),
    .first_err_x(first_err_x3), .first_err_y(first_err_y3),
    .first_err_idx(first_err_idx3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic sv, input logic d,
                       input logic [1:0] xi, input logic [1:0] yi, input logic zi);
    start        = s;
    sample_valid = sv;
    done         = d;
    x            = xi;
    y            = yi;
    z            = zi;
  endtask

  // Runs the 9-vector table; corrupt[i] flips z of vector i. Ends in REPORT.
  task automatic run_table(input logic [8:0] corrupt, input logic [7:0] exp_err,
                           input logic exp_pass);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, tbl[i].x, tbl[i].y, tbl[i].z ^ corrupt[i]);
      tick();
      chk($sformatf("vec_count_step%0d", i), 32'(vec_count), 32'(tbl[i].exp_vec));
    end
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("table_result_valid", 32'(result_valid), 32'd1);
    chk("table_busy_report", 32'(busy), 32'd0);
    chk("table_vec_count", 32'(vec_count), 32'd9);
    chk("table_err_count", 32'(err_count), 32'(exp_err));
    chk("table_pass", 32'(pass), 32'(exp_pass));
    chk("table_fail", 32'(fail), 32'(!exp_pass));
  endtask

  initial begin
    tbl[0] = '{2'd0, 2'd0, 1'b1, 8'd1};
    tbl[1] = '{2'd1, 2'd0, 1'b0, 8'd2};
    tbl[2] = '{2'd1, 2'd1, 1'b1, 8'd3};
    tbl[3] = '{2'd1, 2'd3, 1'b0, 8'd4};
    tbl[4] = '{2'd3, 2'd3, 1'b1, 8'd5};
    tbl[5] = '{2'd2, 2'd3, 1'b0, 8'd6};
    tbl[6] = '{2'd2, 2'd2, 1'b1, 8'd7};
    tbl[7] = '{2'd2, 2'd1, 1'b0, 8'd8};
    tbl[8] = '{2'd2, 2'd0, 1'b0, 8'd9};

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_vec_count", 32'(vec_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Clean session
    run_table(9'b0, 8'd0, 1'b1);
    tick();
    chk("clean_rv_drops", 32'(result_valid), 32'd1 - 32'd1);
    chk("clean_pass_held", 32'(pass), 32'd1);

    // Mismatches forced on (1,3) and (2,0)
    run_table(9'b1_0000_1000, 8'd2, 1'b0);
    chk("err2_first_x", 32'(first_err_x), 32'd1);
    chk("err2_first_y", 32'(first_err_y), 32'd3);
    chk("err2_first_idx", 32'(first_err_idx), 32'd3);
    tick();
    chk("err2_fail_held", 32'(fail), 32'd1);

    // Empty session
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    chk("empty_pass_cleared", 32'(pass), 32'd0);
    chk("empty_fail_cleared", 32'(fail), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("empty_rv", 32'(result_valid), 32'd1);
    chk("empty_vec", 32'(vec_count), 32'd0);
    chk("empty_pass", 32'(pass), 32'd0);
    chk("empty_fail", 32'(fail), 32'd1);
    tick();

    // done coincident with a mismatching last sample
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("coinc_rv", 32'(result_valid), 32'd1);
    chk("coinc_vec", 32'(vec_count), 32'd3);
    chk("coinc_err", 32'(err_count), 32'd1);
    chk("coinc_fail", 32'(fail), 32'd1);
    chk("coinc_pass", 32'(pass), 32'd0);
    chk("coinc_first_idx", 32'(first_err_idx), 32'd2);
    chk("coinc_first_x", 32'(first_err_x), 32'd2);
    chk("coinc_first_y", 32'(first_err_y), 32'd1);
    tick();

    // Saturation on the CNT_W=3 instance
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'd2, 2'd3, !exp_eq(32'd2, 32'd3));
    tick();
    chk("sat_first_x_early", 32'(first_err_x3), 32'd2);
    chk("sat_first_y_early", 32'(first_err_y3), 32'd3);
    chk("sat_err_early", 32'(err_count3), 32'd1);
    for (int i = 1; i < 10; i++) begin
      logic [1:0] xi, yi;
      xi = 2'(i);
      yi = 2'(i * 3);
      drive(1'b0, 1'b1, 1'b0, xi, yi, !exp_eq(32'(xi), 32'(yi)));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("sat_vec3", 32'(vec_count3), 32'd7);
    chk("sat_err3", 32'(err_count3), 32'd7);
    chk("sat_first_idx3", 32'(first_err_idx3), 32'd0);
    chk("sat_first_x3", 32'(first_err_x3), 32'd2);
    chk("sat_first_y3", 32'(first_err_y3), 32'd3);
    chk("sat_vec8", 32'(vec_count), 32'd10);
    chk("sat_err8", 32'(err_count), 32'd10);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("sat_rv3", 32'(result_valid3), 32'd1);
    chk("sat_fail3", 32'(fail3), 32'd1);
    tick();

    // Restart during RUN, then start while in REPORT
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, tbl[i].x, tbl[i].y, tbl[i].z);
      tick();
    end
    chk("restart_pre_vec", 32'(vec_count), 32'd4);
    drive(1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 1'b1);
    tick();
    chk("restart_vec", 32'(vec_count), 32'd1);
    chk("restart_err", 32'(err_count), 32'd1);
    chk("restart_first_idx", 32'(first_err_idx), 32'd0);
    chk("restart_first_x", 32'(first_err_x), 32'd3);
    chk("restart_first_y", 32'(first_err_y), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1);
    tick();
    chk("restart_vec2", 32'(vec_count), 32'd2);
    drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    chk("restart_rv", 32'(result_valid), 32'd1);
    chk("restart_fail", 32'(fail), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("report_start_busy", 32'(busy), 32'd1);
    chk("report_start_rv", 32'(result_valid), 32'd0);
    chk("report_start_fail", 32'(fail), 32'd0);
    chk("report_start_vec", 32'(vec_count), 32'd0);

    // Async reset mid-session after 4 mismatching samples
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, tbl[i].x, tbl[i].y, !tbl[i].z);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk("pre_rst_vec", 32'(vec_count), 32'd4);
    chk("pre_rst_err", 32'(err_count), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_vec", 32'(vec_count), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    chk("arst_first_x", 32'(first_err_x), 32'd0);
    chk("arst_first_idx", 32'(first_err_idx), 32'd0);
    chk("arst_rv", 32'(result_valid), 32'd0);
    chk("arst_pass", 32'(pass), 32'd0);
    chk("arst_fail", 32'(fail), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1);
      tick();
      chk($sformatf("post_rst_vec%0d", i), 32'(vec_count), 32'd0);
      chk($sformatf("post_rst_rv%0d", i), 32'(result_valid), 32'd0);
      chk($sformatf("post_rst_busy%0d", i), 32'(busy), 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
